if_fetch: RTL and testbench

Instruction fetch stage, directly upstream of the decode stage. Owns the fetch PC and issues in-order requests to instruction memory with a req/gnt handshake and a variable response latency (minimum 1 cycle). Buffers returned instructions in a small FIFO and presents them to decode as a PC/instruction pair. Honours decode stalls and EX-stage branch/jump redirects, discarding wrong-path responses still in flight.

---
 rtl/if_fetch.sv | 101 ++++++++++
 tb/tb_if_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch: issues in-order imem requests and buffers {pc, instr} pairs for decode.
// Latency: fetch-to-decode is memory response latency + 1 cycle.
// Backpressure: decode stall holds the head; requests are credit-limited to FIFO_DEPTH in flight or buffered.
module if_fetch #(
    parameter int                ADDR_W     = 32,
    parameter int                INSTR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               stall,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_valid
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_resp_pc;
    logic [CW-1:0]      r_outstanding;
    logic [CW-1:0]      r_drop;
    logic [CW-1:0]      r_count;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic               r_clr_d;
    logic [ADDR_W-1:0]  buf_pc    [FIFO_DEPTH];
    logic [INSTR_W-1:0] buf_instr [FIFO_DEPTH];

    logic [SW-1:0] in_use;
    logic          grant;
    logic          push;
    logic          pop;
    logic          head_vld;

    // Stale in-flight responses will be discarded, so they do not consume buffer credit.
    assign in_use      = SW'(r_outstanding) + SW'(r_count) - SW'(r_drop);
    assign o_imem_req  = !clr && !r_clr_d && !i_redirect && (in_use < SW'(FIFO_DEPTH));
    assign o_imem_addr = r_fetch_pc;
    assign grant       = o_imem_req && i_imem_gnt;
    assign push        = !clr && !i_redirect && i_imem_rvalid && (r_drop == '0);
    assign head_vld    = (r_count != '0);
    assign pop         = !clr && !i_redirect && head_vld && !stall;

    assign o_valid = !clr && head_vld;
    assign o_pc    = o_valid ? buf_pc[r_rd_ptr]    : '0;
    assign o_instr = o_valid ? buf_instr[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_clr_d       <= 1'b1;
        end else begin
            r_clr_d       <= 1'b0;
            r_outstanding <= r_outstanding + CW'(grant) - CW'(i_imem_rvalid);
            if (i_redirect) begin
                // Everything still in flight after this cycle belongs to the wrong path.
                r_fetch_pc <= i_redirect_pc;
                r_resp_pc  <= i_redirect_pc;
                r_drop     <= r_outstanding - CW'(i_imem_rvalid);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (grant)
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                if (i_imem_rvalid && (r_drop != '0))
                    r_drop <= r_drop - CW'(1);
                if (push) begin
                    r_resp_pc <= r_resp_pc + ADDR_W'(4);
                    r_wr_ptr  <= r_wr_ptr + PW'(1);
                end
                if (pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[r_wr_ptr]    <= r_resp_pc;
            buf_instr[r_wr_ptr] <= i_imem_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, hand-written corner sequences, and random traffic
// checked every cycle against a request/epoch reference model with an in-order memory.
module tb_if_fetch;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        clr, stall, i_redirect, i_imem_gnt, i_imem_rvalid;
    logic [31:0] i_redirect_pc, i_imem_rdata;
    logic        o_imem_req, o_valid;
    logic [31:0] o_imem_addr, o_pc, o_instr;

    always #5 clk = ~clk;

    if_fetch #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .stall(stall),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_pc(o_pc), .o_instr(o_instr), .o_valid(o_valid)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct {
        logic        clr, stall, gnt, req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc, instr;
    } vec_t;

    // Requests granted and not yet answered, tagged with the fetch epoch they were issued in.
    req_t        pend[$];
    ent_t        fq[$];
    logic [31:0] fpc = RST_PC;
    int          epoch = 0, cyc = 0, last_due = 0, lat = 1;
    int          total = 0, bad = 0;
    bit          rand_lat = 1'b0, clr_prev = 1'b0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int live();
        int n = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) n++;
        return n;
    endfunction

    function automatic bit resp_due();
        return pend.size() > 0 && pend[0].due <= cyc;
    endfunction

    function automatic vec_t mk(input bit c, input bit s, input bit g, input bit q,
                                input logic [31:0] a, input bit v, input logic [31:0] p,
                                input logic [31:0] i);
        vec_t t;
        t.clr = c; t.stall = s; t.gnt = g; t.req = q;
        t.addr = a; t.valid = v; t.pc = p; t.instr = i;
        return t;
    endfunction

    // One cycle: drive inputs after the falling edge, sample and check, then advance the model.
    task automatic step(input logic c, input logic s, input logic r, input logic [31:0] rp,
                        input logic g);
        logic        rv, e_req, e_valid;
        logic [31:0] e_pc, e_instr;
        req_t        p;
        int          d;
        clr = c; stall = s; i_redirect = r; i_redirect_pc = rp; i_imem_gnt = g;
        rv = resp_due();
        i_imem_rvalid = rv;
        if (rv) i_imem_rdata = pend[0].addr + 32'h100;
        else    i_imem_rdata = $urandom;
        #1;
        e_req   = !c && !clr_prev && !r && (live() + fq.size() < DEPTH);
        e_valid = !c && fq.size() > 0;
        e_pc    = e_valid ? fq[0].pc : 32'h0;
        e_instr = e_valid ? fq[0].instr : 32'h0;
        s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid; s_pc = o_pc; s_instr = o_instr;
        chk("req", 32'(s_req), 32'(e_req));
        if (e_req) chk("addr", s_addr, fpc);
        chk("valid", 32'(s_valid), 32'(e_valid));
        chk("pc", s_pc, e_pc);
        chk("instr", s_instr, e_instr);
        if (c) begin
            pend.delete(); fq.delete();
            fpc = RST_PC; clr_prev = 1'b1; last_due = cyc;
        end else begin
            clr_prev = 1'b0;
            if (!r && !s && fq.size() > 0) void'(fq.pop_front());
            if (rv) begin
                p = pend.pop_front();
                if (p.epoch == epoch && !r) fq.push_back('{p.addr, p.addr + 32'h100});
            end
            if (e_req && g) begin
                d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{fpc, epoch, d});
                fpc = fpc + 32'd4;
            end
            if (r) begin fq.delete(); epoch++; fpc = rp; end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[16];
        bit   found;
        logic [31:0] a0;
        logic c, s, r, g;
        logic [31:0] rp;

        // Startup and stall with 1-cycle memory, gnt always high.
        tbl[0]  = mk(1, 0, 1, 0, 32'h00, 0, 32'h00, 32'h000);
        tbl[1]  = mk(1, 0, 1, 0, 32'h00, 0, 32'h00, 32'h000);
        tbl[2]  = mk(0, 0, 1, 0, 32'h00, 0, 32'h00, 32'h000);
        tbl[3]  = mk(0, 0, 1, 1, 32'h00, 0, 32'h00, 32'h000);
        tbl[4]  = mk(0, 0, 1, 1, 32'h04, 0, 32'h00, 32'h000);
        tbl[5]  = mk(0, 0, 1, 0, 32'h00, 1, 32'h00, 32'h100);
        tbl[6]  = mk(0, 0, 1, 1, 32'h08, 1, 32'h04, 32'h104);
        tbl[7]  = mk(0, 0, 1, 1, 32'h0c, 0, 32'h00, 32'h000);
        tbl[8]  = mk(0, 1, 1, 0, 32'h00, 1, 32'h08, 32'h108);
        tbl[9]  = mk(0, 1, 1, 0, 32'h00, 1, 32'h08, 32'h108);
        tbl[10] = mk(0, 1, 1, 0, 32'h00, 1, 32'h08, 32'h108);
        tbl[11] = mk(0, 1, 1, 0, 32'h00, 1, 32'h08, 32'h108);
        tbl[12] = mk(0, 0, 1, 0, 32'h00, 1, 32'h08, 32'h108);
        tbl[13] = mk(0, 0, 1, 1, 32'h10, 1, 32'h0c, 32'h10c);
        tbl[14] = mk(0, 0, 1, 1, 32'h14, 0, 32'h00, 32'h000);
        tbl[15] = mk(0, 0, 1, 0, 32'h00, 1, 32'h10, 32'h110);
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].clr, tbl[i].stall, 1'b0, 32'h0, tbl[i].gnt);
            chk("t_req", 32'(s_req), 32'(tbl[i].req));
            if (tbl[i].req) chk("t_addr", s_addr, tbl[i].addr);
            chk("t_valid", 32'(s_valid), 32'(tbl[i].valid));
            chk("t_pc", s_pc, tbl[i].pc);
            chk("t_instr", s_instr, tbl[i].instr);
        end

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        step(1, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'h10, 1);
        step(0, 0, 0, 32'h0, 1);
        chk("a_addr0", s_addr, 32'h10);
        step(0, 0, 0, 32'h0, 1);
        chk("a_addr1", s_addr, 32'h14);
        step(0, 0, 1, 32'h200, 1);
        step(0, 0, 0, 32'h0, 1);
        chk("a_req", 32'(s_req), 32'h1);
        chk("a_addr", s_addr, 32'h200);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step(0, 0, 0, 32'h0, 1);
            if (s_valid) found = 1'b1;
        end
        chk("a_seen", 32'(found), 32'h1);
        chk("a_pc", s_pc, 32'h200);
        chk("a_instr", s_instr, 32'h300);

        // Grant withheld: request held at a fixed address while the buffer drains.
        lat = 1;
        step(1, 0, 0, 32'h0, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 32'h0, 1);
        a0 = 32'h0;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 32'h0, 0);
            if (k == 2) a0 = s_addr;
            if (k >= 2) begin
                chk("b_req", 32'(s_req), 32'h1);
                chk("b_valid", 32'(s_valid), 32'h0);
                chk("b_instr", s_instr, 32'h0);
            end
            if (k > 2) chk("b_addr", s_addr, a0);
        end

        // Response, stall and redirect all in the same cycle.
        step(1, 0, 0, 32'h0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 32'h0, 1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (resp_due()) found = 1'b1;
            else step(0, 0, 0, 32'h0, 1);
        end
        chk("c_rv", 32'(found), 32'h1);
        step(0, 1, 1, 32'h40, 1);
        step(0, 0, 0, 32'h0, 1);
        chk("c_empty", 32'(s_valid), 32'h0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(0, 0, 0, 32'h0, 1);
            if (s_valid) found = 1'b1;
        end
        chk("c_seen", 32'(found), 32'h1);
        chk("c_pc", s_pc, 32'h40);
        chk("c_instr", s_instr, 32'h140);

        // Reset while requests are in flight; memory stays silent afterwards.
        lat = 4;
        step(1, 0, 0, 32'h0, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 1);
        chk("d_req0", 32'(s_req), 32'h0);
        chk("d_valid0", 32'(s_valid), 32'h0);
        chk("d_pc0", s_pc, 32'h0);
        chk("d_instr0", s_instr, 32'h0);
        step(0, 0, 0, 32'h0, 1);
        chk("d_req1", 32'(s_req), 32'h0);
        chk("d_valid1", 32'(s_valid), 32'h0);
        step(0, 0, 0, 32'h0, 1);
        chk("d_req2", 32'(s_req), 32'h1);
        chk("d_addr2", s_addr, RST_PC);
        chk("d_valid2", 32'(s_valid), 32'h0);

        // Random traffic with variable latency, including wrap-around redirect targets.
        rand_lat = 1'b1;
        step(1, 0, 0, 32'h0, 1);
        for (int k = 0; k < 4000; k++) begin
            c  = ($urandom_range(0, 199) == 0);
            r  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 2) == 0);
            g  = ($urandom_range(0, 3) != 0);
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFF);
            step(c, s, r, rp, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
